sipo_deserializer: RTL

Serial-in, parallel-out receiver that reassembles MSB-first words from a one-bit stream. It is the receive end of the team's parallel-load left-shift transmitter, which emits `q[WIDTH-1]` first and shifts in at the LSB. A bit counter frames the stream into words. A one-word output holding register with a valid/ready handshake decouples the receiver from its consumer. A sticky overrun flag records any word lost to backpressure.

---
 rtl/sipo_deserializer_pkg.sv | 12 +
 rtl/sipo_deserializer_if.sv | 32 +++
 rtl/sipo_deserializer_core.sv | 66 ++++++
 rtl/sipo_deserializer.sv | 77 +++++++
 4 files changed

// File: rtl/sipo_deserializer_pkg.sv
// Shared definitions for the serial link word format.
// DEFAULT_WIDTH is also used by the transmitter so both ends frame the same word size.
// cnt_width() gives the bit-counter width for a word size (never less than 1).
package sipo_deserializer_pkg;

    localparam int DEFAULT_WIDTH = 4;

    function automatic int cnt_width(input int width);
        return ($clog2(width) < 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/sipo_deserializer_if.sv
// Bus bundle for the SIPO deserializer.
//   sin / sin_valid / sync  : serial stream and word-alignment marker (into receiver)
//   dout / dout_valid       : received word and its valid flag (out of receiver)
//   dout_ready              : consumer accept (into receiver)
//   busy / overrun          : partial-word status and sticky word-loss flag (out)
//   clr_ovr                 : synchronous overrun clear (into receiver)
// slave  = receiver side; master = stream source / consumer side.
interface sipo_deserializer_if
    import sipo_deserializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             sin;
    logic             sin_valid;
    logic             sync;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             busy;
    logic             overrun;
    logic             clr_ovr;

    modport slave (
        input  sin, sin_valid, sync, dout_ready, clr_ovr,
        output dout, dout_valid, busy, overrun
    );

    modport master (
        output sin, sin_valid, sync, dout_ready, clr_ovr,
        input  dout, dout_valid, busy, overrun
    );
endinterface

// File: rtl/sipo_deserializer_core.sv
// sipo_core: shift register and bit counter that frame an MSB-first serial stream.
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   sin_i           : serial bit
//   sin_valid_i     : sample sin_i on this edge
//   sync_i          : restart framing (with sin_valid_i the bit becomes bit 1 of a new word)
//   word_o          : completed word, meaningful while word_done_o is high
//   word_done_o     : high in the cycle whose edge samples the last bit of a word
//   busy_o          : a partial word is in progress
module sipo_core
    import sipo_deserializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin_i,
    input  logic             sin_valid_i,
    input  logic             sync_i,
    output logic [WIDTH-1:0] word_o,
    output logic             word_done_o,
    output logic             busy_o
);
    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        word_done_o = 1'b0;
        if (sync_i && sin_valid_i) begin
            // sync wins over completion: the partial word is dropped silently
            shreg_d = {{(WIDTH-1){1'b0}}, sin_i};
            cnt_d   = CW'(1);
        end else if (sync_i) begin
            shreg_d = '0;
            cnt_d   = '0;
        end else if (sin_valid_i) begin
            shreg_d = {shreg_q[WIDTH-2:0], sin_i};
            if (cnt_q == CNT_LAST) begin
                cnt_d       = '0;
                word_done_o = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Only consumed by registers in the parent, so no output sees sin combinationally.
    assign word_o = {shreg_q[WIDTH-2:0], sin_i};
    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: serial-in parallel-out receiver with a one-word holding
// register, valid/ready handshake and a sticky overrun flag.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bus        : sipo_deserializer_if.slave (stream in, word out, status)
module sipo_deserializer
    import sipo_deserializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sipo_deserializer_if.slave   bus
);
    logic [WIDTH-1:0] word;
    logic             word_done;
    logic             busy;

    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             overrun_q, overrun_d;

    sipo_core #(.WIDTH(WIDTH)) u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .sin_i       (bus.sin),
        .sin_valid_i (bus.sin_valid),
        .sync_i      (bus.sync),
        .word_o      (word),
        .word_done_o (word_done),
        .busy_o      (busy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        logic ovr_set;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        ovr_set      = 1'b0;
        if (word_done) begin
            // a word can land in the same edge the pending one is accepted
            if (!dout_valid_q || bus.dout_ready) begin
                dout_d       = word;
                dout_valid_d = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end else if (dout_valid_q && bus.dout_ready) begin
            dout_valid_d = 1'b0;
        end
        // set beats clear on the same edge
        if (ovr_set) begin
            overrun_d = 1'b1;
        end else if (bus.clr_ovr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.busy       = busy;
    assign bus.overrun    = overrun_q;

endmodule
